// File: rtl/hazard_scoreboard.sv
// Purpose: tracks dest tags of in-flight instructions (EXE/MEM/WB) and flags RAW hazards for ID.
// Latency: hazard is combinational; ID -> Dest_Exe 1 cycle, Dest_Mem 2, Dest_WB 3.
// Backpressure: mem_ready=0 freezes every entry and the stall counter; hazard stays live.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   forwarding_en             1 = only load-use in EXE stalls; 0 = any EXE/MEM producer stalls
//   mem_ready                 0 = whole pipeline frozen this cycle
//   flush                     ID instruction discarded (bubble into EXE)
//   id_*                      instruction currently in ID (valid, wb/load flags, dest, sources)
//   hazard                    stall IF/ID and inject a bubble into EXE
//   Dest_*/WB_EN_*            per-stage destination tag and effective write enable
//   stall_count               saturating count of cycles with hazard & mem_ready
module hazard_scoreboard #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forwarding_en,
    input  logic             mem_ready,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    output logic             hazard,
    output logic [REG_W-1:0] Dest_Exe,
    output logic             WB_EN_Exe,
    output logic [REG_W-1:0] Dest_Mem,
    output logic             WB_EN_Mem,
    output logic [REG_W-1:0] Dest_WB,
    output logic             WB_EN_WB,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             mem_r_en;
        logic [REG_W-1:0] dest;
    } entry_t;

    entry_t           exe_q, exe_d;
    entry_t           mem_q, mem_d;
    entry_t           wb_q,  wb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic exe_hit;
    logic mem_hit;

    function automatic logic match(input entry_t e, input logic [REG_W-1:0] s);
        return e.valid & e.wb_en & (e.dest == s);
    endfunction

    // Source 2 only participates when the instruction really reads it.
    // WB is never checked: the register file writes in the first half-cycle.
    always_comb begin
        exe_hit = match(exe_q, id_src1) | (id_two_src & match(exe_q, id_src2));
        mem_hit = match(mem_q, id_src1) | (id_two_src & match(mem_q, id_src2));
        if (forwarding_en) begin
            // With forwarding only a load in EXE cannot be bypassed in time.
            hazard = id_valid & exe_q.mem_r_en & exe_hit;
        end else begin
            hazard = id_valid & (exe_hit | mem_hit);
        end
    end

    always_comb begin
        exe_d         = exe_q;
        mem_d         = mem_q;
        wb_d          = wb_q;
        stall_count_d = stall_count_q;
        if (mem_ready) begin
            wb_d  = mem_q;
            mem_d = exe_q;
            exe_d = '0;
            // flush and hazard both produce a single bubble; neither masks the other.
            if (!(flush || hazard || !id_valid)) begin
                exe_d.valid    = 1'b1;
                exe_d.wb_en    = id_wb_en;
                exe_d.mem_r_en = id_mem_r_en;
                exe_d.dest     = id_dest;
            end
            if (hazard && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_q         <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            exe_q         <= exe_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Tags are held even when the stage is not valid; enables qualify them.
    assign Dest_Exe    = exe_q.dest;
    assign WB_EN_Exe   = exe_q.valid & exe_q.wb_en;
    assign Dest_Mem    = mem_q.dest;
    assign WB_EN_Mem   = mem_q.valid & mem_q.wb_en;
    assign Dest_WB     = wb_q.dest;
    assign WB_EN_WB    = wb_q.valid & wb_q.wb_en;
    assign stall_count = stall_count_q;

endmodule
